fetch_prefetch: RTL and testbench
=================================

Name: fetch_prefetch

Overview:
- Parametrised instruction-fetch front end for the pipelined RV32 core; replaces the fixed PC-register-plus-combinational-imem fetch path.
- Issues sequential word fetches to an instruction memory with a valid/ready request channel and in-order response channel of arbitrary latency.
- Buffers returned instructions with their PCs in a DEPTH-entry FIFO and presents them to decode through a valid/ready handshake.
- Supports redirect (branch/jump/trap) with flush and discard of stale in-flight responses, plus misaligned-target fault reporting.

Parameters:
XLEN, 32, address/instruction width
DEPTH, 4, queue entries and maximum in-flight requests (power of two, >=2)
RESET_PC, 32'h0000_0000, fetch address after reset

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
fetch_en  in  1  permits new requests when high
imem_req_valid  out  1  request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  XLEN  word-aligned fetch address
imem_resp_valid  in  1  response valid, in request order, one per accepted request
imem_resp_data  in  XLEN  instruction word
redirect  in  1  flush and restart at redirect_pc
redirect_pc  in  XLEN  new fetch target
out_valid  out  1  queue head valid
out_ready  in  1  decode consumes head
out_pc  out  XLEN  PC of head
out_instr  out  XLEN  instruction of head
fault  out  1  misaligned redirect target pending
fault_pc  out  XLEN  offending target

Behaviour:
- Reset (asserted low): fetch_pc = resp_pc = RESET_PC; occupancy, outstanding, drop_count = 0; state RUN; imem_req_valid, out_valid, fault = 0; fault_pc, out_pc, out_instr = 0. No request in the first cycle after reset deassertion.
- Counters: occupancy and outstanding are $clog2(DEPTH+1) bits. Invariant: occupancy + outstanding - drop_count <= DEPTH.
- States: RUN, FAULT.
- RUN issue: imem_req_valid = fetch_en & !redirect & (occupancy + outstanding - drop_count < DEPTH) & (outstanding < DEPTH); imem_req_addr = fetch_pc. On valid & ready: outstanding += 1, fetch_pc += 4, wrapping modulo 2^XLEN. The address stays stable while valid and not ready unless redirect is asserted.
- Response: on imem_resp_valid, outstanding -= 1.
  - If drop_count > 0: drop_count -= 1; data discarded.
  - Otherwise push {resp_pc, imem_resp_data}; resp_pc += 4. The credit rule guarantees no overflow; a push when full is an assertion failure.
- Output: the head is visible combinationally from registered queue state. Pop on out_valid & out_ready.
  - Push and pop in the same cycle leaves occupancy unchanged.
  - A push into an empty queue makes out_valid = 1 the next cycle. There is no fall-through.
- Redirect (highest priority): queue flushed (occupancy = 0, out_valid = 0 next cycle). Any pop or push that cycle is ignored. No request is issued that cycle.
  - drop_count = outstanding after this cycle's response decrement. A response arriving in the redirect cycle is discarded and is not counted.
  - If redirect_pc[1:0] == 0: fetch_pc = resp_pc = redirect_pc; state RUN; fault = 0.
  - Else: state FAULT; fault = 1; fault_pc = redirect_pc.
- FAULT: no requests issued. Stale responses still drain via drop_count. Queue stays empty; out_valid = 0. Only redirect leaves FAULT, by the same rules as above.
- fetch_en low: pending un-accepted request is withdrawn. In-flight responses still land; the queue still drains.
- Reset mid-operation: all state is cleared immediately. The memory side is also reset, so responses to pre-reset requests never arrive.

Test Plan:
- Reset release, fetch_en = 1, memory ready always, 1-cycle latency, out_ready = 1 -> requests at 0x0, 0x4, 0x8…; out_pc/out_instr sequence 0x0, 0x4, … with sustained one instruction per cycle after fill.
- out_ready = 0, DEPTH = 4, latency 3 -> exactly 4 requests issued, imem_req_valid then held low, out_valid = 1 with out_pc = 0x0. Raising out_ready drains 0x0–0xC in order and requesting resumes at 0x10.
- Three requests in flight (0x10, 0x14, 0x18), redirect to 0x200 -> the three stale responses are discarded. The first out_pc after redirect is 0x200, followed by 0x204.
- Redirect in the same cycle as a response and a pop -> response dropped, occupancy 0, drop_count equals remaining in-flight count. The next delivered out_pc equals redirect_pc.
- Redirect to 0x102 -> fault = 1, fault_pc = 0x102, no requests. A later redirect to 0x100 clears fault and fetches 0x100.
- imem_req_ready held low for 5 cycles -> imem_req_addr stable at the same value and fetch_pc not advanced. Asynchronous reset asserted mid-stream -> all outputs 0 within the same cycle, restart at RESET_PC.

Source files
------------

// File: rtl/fetch_prefetch.sv
// Instruction-fetch front end for the pipelined RV32 core.
// The block issues sequential word fetches and buffers the returned instructions
// with their PCs in a DEPTH-entry queue that feeds decode.
// A credit check keeps every in-flight response a guaranteed queue slot.
// On a redirect, responses still in flight are counted off and discarded.
module fetch_prefetch #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            fetch_en,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_instr,
  output logic            fault,
  output logic [XLEN-1:0] fault_pc
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic {RUN, FAULT} state_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] fetch_pc, resp_pc, fault_pc_r;
  logic [CW-1:0]   occupancy, outstanding, drop_count;
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic            run_ok;

  logic [XLEN-1:0] pc_q    [DEPTH];
  logic [XLEN-1:0] instr_q [DEPTH];

  logic [CW:0]     credit_used;
  logic            req_fire, push, pop, target_aligned;
  logic [CW-1:0]   outstanding_nxt;

  // Slots already promised: queued entries plus live (non-discarded) requests.
  assign credit_used    = {1'b0, occupancy} + {1'b0, outstanding} - {1'b0, drop_count};
  assign target_aligned = (redirect_pc[1:0] == 2'b00);

  // run_ok holds off requests during the first cycle after reset release.
  assign imem_req_valid = run_ok && (state == RUN) && fetch_en && !redirect &&
                          (credit_used < (CW+1)'(DEPTH)) && (outstanding < CW'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A redirect overrides both queue operations in its cycle.
  assign push = imem_resp_valid && (drop_count == '0) && !redirect && (state == RUN);
  assign pop  = out_valid && out_ready && !redirect;

  assign outstanding_nxt = outstanding + CW'(req_fire) - CW'(imem_resp_valid);

  // The head is visible straight from registered state; outputs are zero when empty.
  assign out_valid = (occupancy != '0);
  assign out_pc    = out_valid ? pc_q[rd_ptr]    : '0;
  assign out_instr = out_valid ? instr_q[rd_ptr] : '0;
  assign fault     = (state == FAULT);
  assign fault_pc  = fault_pc_r;

  // Next state: only a redirect moves between RUN and FAULT.
  always_comb begin
    state_nxt = state;
    if (redirect) begin
      state_nxt = target_aligned ? RUN : FAULT;
    end
  end

  // State register and all control counters, pointers and PCs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= RUN;
      run_ok      <= 1'b0;
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      fault_pc_r  <= '0;
      occupancy   <= '0;
      outstanding <= '0;
      drop_count  <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      state       <= state_nxt;
      run_ok      <= 1'b1;
      outstanding <= outstanding_nxt;
      if (redirect) begin
        // Every request still in flight after this cycle returns stale data.
        drop_count <= outstanding_nxt;
        occupancy  <= '0;
        rd_ptr     <= '0;
        wr_ptr     <= '0;
        if (target_aligned) begin
          fetch_pc <= redirect_pc;
          resp_pc  <= redirect_pc;
        end else begin
          fault_pc_r <= redirect_pc;
        end
      end else begin
        if (imem_resp_valid && (drop_count != '0)) begin
          drop_count <= drop_count - CW'(1);
        end
        if (req_fire) begin
          fetch_pc <= fetch_pc + XLEN'(4);
        end
        if (push) begin
          resp_pc <= resp_pc + XLEN'(4);
          wr_ptr  <= wr_ptr + PW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PW'(1);
        end
        occupancy <= occupancy + CW'(push) - CW'(pop);
      end
    end
  end

  // Queue storage: the data path is written on push and needs no reset.
  always_ff @(posedge clock) begin
    if (push) begin
      pc_q[wr_ptr]    <= resp_pc;
      instr_q[wr_ptr] <= imem_resp_data;
    end
  end

  // The credit rule must make a push into a full queue impossible.
  push_when_full: assert property (@(posedge clock) disable iff (!reset)
                                   !(push && (occupancy == CW'(DEPTH))));

endmodule

// File: tb/tb_fetch_prefetch.sv
// Randomised bench for fetch_prefetch.
// An in-order memory model with random latency feeds the DUT.
// A queue-level reference predicts the requests, the decode stream and the fault state.
module tb_fetch_prefetch;

  localparam int DEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        fetch_en = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = 32'h0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        fault;
  logic [31:0] fault_pc;

  fetch_prefetch #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clock(clock), .reset(reset), .fetch_en(fetch_en),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_instr(out_instr), .fault(fault), .fault_pc(fault_pc)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } fl_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  fl_t         inflight[$];
  ent_t        expq[$];
  logic [31:0] m_fetch_pc = RESET_PC;
  logic [31:0] m_fault_pc = 32'h0;
  bit          m_fault = 1'b0;
  bit          started = 1'b0;
  int          cyc = 0;
  int          reqs = 0;
  int          pops = 0;
  int          n_vec = 0;
  int          n_err = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] rand_target();
    logic [31:0] t;
    int r;
    r = int'($urandom_range(0, 99));
    t = 32'($urandom_range(0, 255)) << 2;
    if (r < 25) t[1:0] = 2'($urandom_range(1, 3));
    if (r >= 90) t = 32'hFFFF_FFF4;
    return t;
  endfunction

  task automatic model_reset();
    inflight.delete();
    expq.delete();
    m_fetch_pc = RESET_PC;
    m_fault = 1'b0;
    started = 1'b0;
  endtask

  // One clock cycle: drive memory response, check outputs, advance model.
  task automatic step(input int lat_max);
    fl_t         e;
    ent_t        h;
    bit          rv, rf, exp_rv, m_pop;
    int          live;
    logic [31:0] addr_s;
    rv = (inflight.size() > 0) && (inflight[0].due <= cyc);
    imem_resp_valid = rv;
    imem_resp_data  = rv ? mem_word(inflight[0].addr) : 32'h0;
    #1;
    live = expq.size();
    foreach (inflight[i]) if (!inflight[i].stale) live++;
    exp_rv = started && fetch_en && !redirect && !m_fault &&
             (live < DEPTH) && (inflight.size() < DEPTH);
    chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
    if (exp_rv) chk("req_addr", imem_req_addr, m_fetch_pc);
    chk("out_valid", 32'(out_valid), 32'(expq.size() > 0));
    if (expq.size() > 0) begin
      chk("out_pc", out_pc, expq[0].pc);
      chk("out_instr", out_instr, expq[0].ins);
    end
    chk("fault", 32'(fault), 32'(m_fault));
    if (m_fault) chk("fault_pc", fault_pc, m_fault_pc);
    rf     = imem_req_valid && imem_req_ready;
    addr_s = imem_req_addr;
    m_pop  = (expq.size() > 0) && out_ready && !redirect;
    if (out_valid && out_ready) pops++;
    @(posedge clock);
    cyc++;
    if (rv) begin
      e = inflight.pop_front();
      if (!redirect && !e.stale) begin
        if (m_pop) void'(expq.pop_front());
        m_pop = 1'b0;
        h.pc = e.addr;
        h.ins = mem_word(e.addr);
        expq.push_back(h);
      end
    end
    if (redirect) begin
      expq.delete();
      for (int i = 0; i < inflight.size(); i++) begin
        e = inflight[i];
        e.stale = 1'b1;
        inflight[i] = e;
      end
      if (redirect_pc[1:0] == 2'b00) begin
        m_fault = 1'b0;
        m_fetch_pc = redirect_pc;
      end else begin
        m_fault = 1'b1;
        m_fault_pc = redirect_pc;
      end
    end else begin
      if (m_pop) void'(expq.pop_front());
      if (rf) m_fetch_pc = m_fetch_pc + 32'd4;
    end
    if (rf) begin
      reqs++;
      e.addr  = addr_s;
      e.due   = cyc + int'($urandom_range(1, lat_max)) - 1;
      e.stale = 1'b0;
      inflight.push_back(e);
    end
    started = 1'b1;
    @(negedge clock);
  endtask

  task automatic run(input int n, input int p_rdy, input int p_ordy, input int p_fen,
                     input int p_redir, input int lat_max);
    for (int k = 0; k < n; k++) begin
      imem_req_ready = (int'($urandom_range(0, 99)) < p_rdy);
      out_ready      = (int'($urandom_range(0, 99)) < p_ordy);
      fetch_en       = (int'($urandom_range(0, 99)) < p_fen);
      if (int'($urandom_range(0, 99)) < p_redir) begin
        redirect = 1'b1;
        redirect_pc = rand_target();
      end else begin
        redirect = 1'b0;
        redirect_pc = 32'h0;
      end
      step(lat_max);
    end
    redirect = 1'b0;
    redirect_pc = 32'h0;
  endtask

  task automatic do_redirect(input logic [31:0] target, input int lat_max);
    redirect = 1'b1;
    redirect_pc = target;
    step(lat_max);
    redirect = 1'b0;
    redirect_pc = 32'h0;
  endtask

  initial begin
    int r0, p0;
    repeat (3) @(negedge clock);
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_fault_pc", fault_pc, 32'h0);
    @(negedge clock);
    reset = 1'b1;
    model_reset();

    // Decode stalled, latency 3: exactly DEPTH requests, then drain and resume.
    r0 = reqs;
    run(12, 100, 0, 100, 0, 3);
    chk("fill_reqs", 32'(reqs - r0), 32'(DEPTH));
    run(16, 100, 100, 100, 0, 3);

    // Single-cycle memory: one instruction per cycle once full.
    run(20, 100, 100, 100, 0, 1);
    p0 = pops;
    run(20, 100, 100, 100, 0, 1);
    chk("throughput", 32'(pops - p0), 32'd20);

    // Redirect with several requests in flight.
    run(3, 100, 100, 100, 0, 4);
    do_redirect(32'h200, 4);
    run(15, 100, 100, 100, 0, 4);

    // Misaligned target faults and holds; an aligned redirect recovers.
    do_redirect(32'h102, 2);
    r0 = reqs;
    run(6, 100, 100, 100, 0, 2);
    chk("fault_no_reqs", 32'(reqs - r0), 32'h0);
    do_redirect(32'h100, 2);
    run(10, 100, 100, 100, 0, 2);

    // Memory back-pressure: address must hold.
    run(5, 0, 100, 100, 0, 2);
    run(10, 100, 100, 100, 0, 2);

    // Mixed random traffic with redirects.
    run(600, 70, 60, 85, 4, 4);

    // Asynchronous reset mid-stream.
    fetch_en = 1'b1;
    imem_req_ready = 1'b1;
    #2;
    reset = 1'b0;
    imem_resp_valid = 1'b0;
    #1;
    chk("arst_req_valid", 32'(imem_req_valid), 32'h0);
    chk("arst_req_addr", imem_req_addr, RESET_PC);
    chk("arst_out_valid", 32'(out_valid), 32'h0);
    chk("arst_out_pc", out_pc, 32'h0);
    chk("arst_out_instr", out_instr, 32'h0);
    chk("arst_fault", 32'(fault), 32'h0);
    chk("arst_fault_pc", fault_pc, 32'h0);
    model_reset();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    run(300, 50, 50, 90, 6, 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
